// File: rtl/f2_fetch_align_if.sv
// rtl/f2_fetch_align_if.sv - F2 fetch-align pipeline-side and imem-side signal bundle
interface f2_fetch_align_if;
    logic [31:0] pc_in;
    logic        is_a_inst_in;
    logic        flushed_in;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        wait_req;
    logic        fetch_timeout;

    modport master (
        output pc_in, is_a_inst_in, flushed_in, imem_rdata, imem_rvalid, stall_in, flush_in,
        input  inst_out, pc_out, valid_out, wait_req, fetch_timeout
    );

    modport slave (
        input  pc_in, is_a_inst_in, flushed_in, imem_rdata, imem_rvalid, stall_in, flush_in,
        output inst_out, pc_out, valid_out, wait_req, fetch_timeout
    );
endinterface

// File: rtl/f2_fetch_align.sv
// rtl/f2_fetch_align.sv - F2 stage: pairs imem data with its PC, holds it across stalls, waits on misses
module f2_fetch_align (
    input  logic             clk,
    input  logic             nrst,
    f2_fetch_align_if.slave  bus
);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HELD  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        fetch_timeout_q, fetch_timeout_d;

    logic [31:0] inst_d, pc_d;
    logic        valid_d, wait_req_d;
    logic        fetch_ok;

    assign fetch_ok = bus.is_a_inst_in & ~bus.flushed_in;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q         <= S_EMPTY;
            hold_inst_q     <= 32'h0;
            hold_pc_q       <= 32'h0;
            wait_cnt_q      <= 4'd0;
            fetch_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_inst_q     <= hold_inst_d;
            hold_pc_q       <= hold_pc_d;
            wait_cnt_q      <= wait_cnt_d;
            fetch_timeout_q <= fetch_timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        wait_cnt_d  = wait_cnt_q;
        inst_d      = NOP_INST;
        pc_d        = 32'h0;
        valid_d     = 1'b0;
        wait_req_d  = 1'b0;

        case (state_q)
            S_EMPTY: begin
                if (fetch_ok) begin
                    if (bus.imem_rvalid) begin
                        inst_d  = bus.imem_rdata;
                        pc_d    = bus.pc_in;
                        valid_d = 1'b1;
                        if (bus.stall_in) begin
                            state_d     = S_HELD;
                            hold_inst_d = bus.imem_rdata;
                            hold_pc_d   = bus.pc_in;
                        end
                    end else begin
                        wait_req_d = 1'b1;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_HELD: begin
                inst_d  = hold_inst_q;
                pc_d    = hold_pc_q;
                valid_d = 1'b1;
                if (!bus.stall_in) begin
                    state_d = S_EMPTY;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    inst_d     = bus.imem_rdata;
                    pc_d       = bus.pc_in;
                    valid_d    = 1'b1;
                    wait_cnt_d = 4'd0;
                    if (bus.stall_in) begin
                        state_d     = S_HELD;
                        hold_inst_d = bus.imem_rdata;
                        hold_pc_d   = bus.pc_in;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end else begin
                    wait_req_d = 1'b1;
                    if (wait_cnt_q != 4'd15) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // Flush only redirects the next state; this cycle's outputs still reflect state_q.
        if (bus.flush_in) begin
            state_d    = S_EMPTY;
            wait_cnt_d = 4'd0;
        end

        fetch_timeout_d = fetch_timeout_q | (wait_cnt_d == 4'd15);
    end

    assign bus.inst_out      = inst_d;
    assign bus.pc_out        = pc_d;
    assign bus.valid_out     = valid_d;
    assign bus.wait_req      = wait_req_d;
    assign bus.fetch_timeout = fetch_timeout_q;
endmodule

// File: tb/tb_f2_fetch_align.sv
// tb/tb_f2_fetch_align.sv - directed scoreboard bench for f2_fetch_align
module tb_f2_fetch_align;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic        wreq;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    f2_fetch_align_if bus ();

    f2_fetch_align dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    task automatic drive(input logic rn, input logic [31:0] pc, input logic isi, input logic fl,
                         input logic [31:0] rd, input logic rv, input logic st, input logic fi);
        @(negedge clk);
        nrst             = rn;
        bus.pc_in        = pc;
        bus.is_a_inst_in = isi;
        bus.flushed_in   = fl;
        bus.imem_rdata   = rd;
        bus.imem_rvalid  = rv;
        bus.stall_in     = st;
        bus.flush_in     = fi;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        #1;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty got 0 entries required 1", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (bus.inst_out === e.inst) else begin
                errors++; $error("FAIL %s inst_out got %h required %h", tag, bus.inst_out, e.inst);
            end
            checks++;
            assert (bus.pc_out === e.pc) else begin
                errors++; $error("FAIL %s pc_out got %h required %h", tag, bus.pc_out, e.pc);
            end
            checks++;
            assert (bus.valid_out === e.valid) else begin
                errors++; $error("FAIL %s valid_out got %b required %b", tag, bus.valid_out, e.valid);
            end
            checks++;
            assert (bus.wait_req === e.wreq) else begin
                errors++; $error("FAIL %s wait_req got %b required %b", tag, bus.wait_req, e.wreq);
            end
            checks++;
            assert (bus.fetch_timeout === e.tmo) else begin
                errors++; $error("FAIL %s fetch_timeout got %b required %b", tag, bus.fetch_timeout, e.tmo);
            end
        end
        checks++;
        assert (!(bus.valid_out === 1'b1 && bus.wait_req === 1'b1)) else begin
            errors++; $error("FAIL %s exclusive valid/wait got both 1 required not both", tag);
        end
    endtask

    task automatic step(input string tag, input logic rn, input logic [31:0] pc, input logic isi,
                        input logic fl, input logic [31:0] rd, input logic rv, input logic st,
                        input logic fi, input logic [31:0] einst, input logic [31:0] epc,
                        input logic ev, input logic ew, input logic et);
        exp_t e;
        drive(rn, pc, isi, fl, rd, rv, st, fi);
        e.inst = einst; e.pc = epc; e.valid = ev; e.wreq = ew; e.tmo = et;
        sb_q.push_back(e);
        check_out(tag);
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] exp_cnt);
        checks++;
        assert (dut.wait_cnt_q === exp_cnt) else begin
            errors++; $error("FAIL %s wait_cnt got %0d required %0d", tag, dut.wait_cnt_q, exp_cnt);
        end
    endtask

    initial begin
        int ec;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step("reset_idle", 1, 32'h0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, NOP, 32'h0, 0, 0, 0);
        check_cnt("reset_cnt", 4'd0);

        // Bubble with flushed_in discards rdata
        step("flushed_bubble", 1, 32'h80, 1, 1, 32'h1234_5678, 1, 0, 0, NOP, 32'h0, 0, 0, 0);

        // Hit
        step("hit", 1, 32'h100, 1, 0, 32'h00A0_0093, 1, 0, 0, 32'h00A0_0093, 32'h100, 1, 0, 0);
        step("hit_after", 1, 32'h0, 0, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 0, 0);

        // Stall capture, rdata changes while held
        step("stall_c1", 1, 32'h100, 1, 0, 32'h00A0_0093, 1, 1, 0, 32'h00A0_0093, 32'h100, 1, 0, 0);
        step("stall_c2", 1, 32'h100, 1, 0, 32'hDEAD_BEEF, 1, 1, 0, 32'h00A0_0093, 32'h100, 1, 0, 0);
        step("stall_c3", 1, 32'h100, 1, 0, 32'hDEAD_BEEF, 1, 1, 0, 32'h00A0_0093, 32'h100, 1, 0, 0);
        step("stall_release", 1, 32'h100, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 32'h00A0_0093, 32'h100, 1, 0, 0);
        step("stall_empty", 1, 32'h104, 1, 0, 32'h1111_1113, 1, 0, 0, 32'h1111_1113, 32'h104, 1, 0, 0);

        // Miss for two cycles then data
        step("miss_c1", 1, 32'h200, 1, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 1, 0);
        check_cnt("miss_cnt1", 4'd0);
        step("miss_c2", 1, 32'h200, 1, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 1, 0);
        check_cnt("miss_cnt2", 4'd0);
        step("miss_data", 1, 32'h200, 1, 0, 32'h0020_8133, 1, 0, 0, 32'h0020_8133, 32'h200, 1, 0, 0);
        check_cnt("miss_cnt3", 4'd1);
        step("miss_after", 1, 32'h0, 0, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 0, 0);
        check_cnt("miss_cnt_clr", 4'd0);

        // Timeout: counter saturates, sticky flag set at 15
        for (int j = 1; j <= 20; j++) begin
            step("tmo_wait", 1, 32'h300, 1, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 1, (j >= 17));
            ec = (j < 2) ? 0 : (((j - 2) > 15) ? 15 : (j - 2));
            check_cnt("tmo_cnt", 4'(ec));
        end
        step("tmo_data", 1, 32'h300, 1, 0, 32'h0001_3579, 1, 0, 0, 32'h0001_3579, 32'h300, 1, 0, 1);
        step("tmo_sticky", 1, 32'h0, 0, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 0, 1);
        check_cnt("tmo_cnt_clr", 4'd0);

        // Flush dominates stall while HELD
        step("fl_capture", 1, 32'h400, 1, 0, 32'h0000_00AA, 1, 1, 0, 32'h0000_00AA, 32'h400, 1, 0, 1);
        step("fl_held_flush", 1, 32'h400, 1, 0, 32'h0BAD_0BAD, 1, 1, 1, 32'h0000_00AA, 32'h400, 1, 0, 1);
        step("fl_bubble", 1, 32'h404, 1, 1, 32'h0BAD_0BAD, 1, 0, 0, NOP, 32'h0, 0, 0, 1);

        // Reset mid-WAIT after the counter reaches 5
        step("rw_miss", 1, 32'h500, 1, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 1, 1);
        for (int j = 0; j < 6; j++) begin
            step("rw_wait", 1, 32'h500, 1, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 1, 1);
        end
        check_cnt("rw_cnt5", 4'd5);
        step("rw_reset", 0, 32'h500, 1, 0, 32'h0, 0, 1, 1, NOP, 32'h0, 0, 1, 1);
        step("rw_after", 1, 32'h0, 0, 0, 32'h0, 0, 0, 0, NOP, 32'h0, 0, 0, 0);
        check_cnt("rw_cnt_clr", 4'd0);
        step("rw_empty_hit", 1, 32'h508, 1, 0, 32'h0055_0013, 1, 0, 0, 32'h0055_0013, 32'h508, 1, 0, 0);

        // Reset while HELD leaves no residue
        step("rh_capture", 1, 32'h600, 1, 0, 32'h0006_00AB, 1, 1, 0, 32'h0006_00AB, 32'h600, 1, 0, 0);
        step("rh_reset", 0, 32'h600, 1, 0, 32'h0, 0, 1, 0, 32'h0006_00AB, 32'h600, 1, 0, 0);
        step("rh_after", 1, 32'h604, 1, 0, 32'h0000_0777, 1, 0, 0, 32'h0000_0777, 32'h604, 1, 0, 0);
        checks++;
        assert (dut.hold_inst_q === 32'h0) else begin
            errors++; $error("FAIL rh_hold_inst got %h required %h", dut.hold_inst_q, 32'h0);
        end
        checks++;
        assert (dut.hold_pc_q === 32'h0) else begin
            errors++; $error("FAIL rh_hold_pc got %h required %h", dut.hold_pc_q, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
